matmul_tile_scheduler: RTL and testbench

Sequences a tiled matrix multiply C[m×n] = A[m×k] · B[k×n] on the SIZE×SIZE systolic accelerator. It walks the output tiles and k-steps and issues DMA fetch requests for the A and B tiles. It pulses the array's compute and writeback stages and reports completion. The block sits between the accelerator's software-visible configuration registers and the DMA, compute and writeback engines.

---
 rtl/matmul_tile_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// Tile sequencer for C = A*B on a SIZE x SIZE systolic array.
// Config in; DMA fetch, compute and writeback handshakes out; busy/done/err status.
module matmul_tile_scheduler #(
  parameter int SIZE = 8,
  parameter int EB = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_base_a,
  input  logic [31:0] addr_base_b,
  input  logic [31:0] addr_base_c,
  input  logic [31:0] m,
  input  logic [31:0] k,
  input  logic [31:0] n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic        dma_sel,
  output logic [31:0] dma_addr,
  output logic [31:0] dma_stride,
  input  logic        dma_done,
  output logic        comp_start,
  output logic        comp_first,
  output logic        comp_last,
  input  logic        comp_done,
  output logic        wb_start,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_stride,
  input  logic        wb_done
);
  localparam int LG = $clog2(SIZE);
  localparam logic [31:0] SZ_EB = 32'(SIZE * EB);
  localparam logic [31:0] EB32 = 32'(EB);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_A, S_WAIT_A, S_REQ_B, S_WAIT_B,
    S_COMP, S_WAIT_C, S_WB, S_WAIT_W, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] base_a, base_b, base_c;
  logic [31:0] k_q, n_q;
  logic [31:0] mt, kt, nt;
  logic [31:0] ti, tj, tk;
  // Byte offsets kept incrementally:
  // a_row = ti*SIZE*k*EB, b_row = tk*SIZE*n*EB,
  // c_row = ti*SIZE*n*EB, k_col = tk*SIZE*EB,
  // n_col = tj*SIZE*EB.
  logic [31:0] a_row, b_row, c_row, k_col, n_col;
  logic cfg_bad, last_tk, last_tj, last_ti;

  assign cfg_bad = (m == '0) || (k == '0) || (n == '0)
                || (m[LG-1:0] != '0)
                || (k[LG-1:0] != '0)
                || (n[LG-1:0] != '0);

  assign last_tk = (tk == kt - 32'd1);
  assign last_tj = (tj == nt - 32'd1);
  assign last_ti = (ti == mt - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      err    <= 1'b0;
      base_a <= '0;
      base_b <= '0;
      base_c <= '0;
      k_q    <= '0;
      n_q    <= '0;
      mt     <= '0;
      kt     <= '0;
      nt     <= '0;
      ti     <= '0;
      tj     <= '0;
      tk     <= '0;
      a_row  <= '0;
      b_row  <= '0;
      c_row  <= '0;
      k_col  <= '0;
      n_col  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        err    <= cfg_bad;
        base_a <= addr_base_a;
        base_b <= addr_base_b;
        base_c <= addr_base_c;
        k_q    <= k;
        n_q    <= n;
        mt     <= m >> LG;
        kt     <= k >> LG;
        nt     <= n >> LG;
        ti     <= '0;
        tj     <= '0;
        tk     <= '0;
        a_row  <= '0;
        b_row  <= '0;
        c_row  <= '0;
        k_col  <= '0;
        n_col  <= '0;
      end
      if (state == S_WAIT_C && comp_done && !last_tk) begin
        tk    <= tk + 32'd1;
        k_col <= k_col + SZ_EB;
        b_row <= b_row + n_q * SZ_EB;
      end
      if (state == S_WAIT_W && wb_done) begin
        tk    <= '0;
        k_col <= '0;
        b_row <= '0;
        if (!last_tj) begin
          tj    <= tj + 32'd1;
          n_col <= n_col + SZ_EB;
        end else begin
          tj    <= '0;
          n_col <= '0;
          ti    <= ti + 32'd1;
          a_row <= a_row + k_q * SZ_EB;
          c_row <= c_row + n_q * SZ_EB;
        end
      end
    end
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    dma_req    = 1'b0;
    dma_sel    = 1'b0;
    dma_addr   = '0;
    dma_stride = '0;
    comp_start = 1'b0;
    comp_first = 1'b0;
    comp_last  = 1'b0;
    wb_start   = 1'b0;
    wb_addr    = '0;
    wb_stride  = '0;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = cfg_bad ? S_DONE : S_REQ_A;
      end
      S_REQ_A: begin
        busy       = 1'b1;
        dma_req    = 1'b1;
        dma_addr   = base_a + a_row + k_col;
        dma_stride = k_q * EB32;
        if (dma_ack)
          state_nx = S_WAIT_A;
      end
      S_WAIT_A: begin
        busy = 1'b1;
        if (dma_done)
          state_nx = S_REQ_B;
      end
      S_REQ_B: begin
        busy       = 1'b1;
        dma_req    = 1'b1;
        dma_sel    = 1'b1;
        dma_addr   = base_b + b_row + n_col;
        dma_stride = n_q * EB32;
        if (dma_ack)
          state_nx = S_WAIT_B;
      end
      S_WAIT_B: begin
        busy = 1'b1;
        if (dma_done)
          state_nx = S_COMP;
      end
      S_COMP: begin
        busy       = 1'b1;
        comp_start = 1'b1;
        comp_first = (tk == '0);
        comp_last  = last_tk;
        state_nx   = S_WAIT_C;
      end
      S_WAIT_C: begin
        busy = 1'b1;
        if (comp_done)
          state_nx = last_tk ? S_WB : S_REQ_A;
      end
      S_WB: begin
        busy      = 1'b1;
        wb_start  = 1'b1;
        wb_addr   = base_c + c_row + n_col;
        wb_stride = n_q * EB32;
        state_nx  = S_WAIT_W;
      end
      S_WAIT_W: begin
        busy      = 1'b1;
        wb_addr   = base_c + c_row + n_col;
        wb_stride = n_q * EB32;
        if (wb_done)
          state_nx = (last_tj && last_ti) ? S_DONE : S_REQ_A;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: DMA/compute/writeback responder,
// scoreboard of expected tile requests, scenario tasks.
module tb_matmul_tile_scheduler;
  localparam int SIZE = 8;
  localparam int EB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic        dma_ack, dma_done, comp_done, wb_done;
  logic [31:0] addr_base_a, addr_base_b, addr_base_c;
  logic [31:0] m, k, n;
  logic        busy, done, err, dma_req, dma_sel;
  logic        comp_start, comp_first, comp_last, wb_start;
  logic [31:0] dma_addr, dma_stride, wb_addr, wb_stride;

  matmul_tile_scheduler #(.SIZE(SIZE), .EB(EB)) dut (
    .clk(clk), .rst(rst),
    .addr_base_a(addr_base_a), .addr_base_b(addr_base_b),
    .addr_base_c(addr_base_c),
    .m(m), .k(k), .n(n),
    .start(start), .busy(busy), .done(done), .err(err),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_sel(dma_sel),
    .dma_addr(dma_addr), .dma_stride(dma_stride),
    .dma_done(dma_done),
    .comp_start(comp_start), .comp_first(comp_first),
    .comp_last(comp_last), .comp_done(comp_done),
    .wb_start(wb_start), .wb_addr(wb_addr),
    .wb_stride(wb_stride), .wb_done(wb_done)
  );

  wire [136:0] outs = {busy, done, err, dma_req, dma_sel,
                       comp_start, comp_first, comp_last, wb_start,
                       dma_addr, dma_stride, wb_addr, wb_stride};

  int passed = 0;
  int total = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] qw[$];
  logic [1:0]  qc[$];

  int na, nb, nc, nfirst, nlast, nw, ndone;
  logic mon_en, resp_en, prev_req;
  logic [63:0] wb_hold;

  // Monitor: pops the scoreboard on each new request / pulse.
  initial begin
    logic [63:0] e;
    logic [1:0]  f;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (dma_req && !prev_req) begin
          total++;
          if (!dma_sel) begin
            na++;
            if (qa.size() == 0) begin
              $display("FAIL a_req unexpected got=%h", dma_addr);
            end else begin
              e = qa.pop_front();
              if ({dma_addr, dma_stride} !== e)
                $display("FAIL a_req got=%h/%h exp=%h/%h",
                  dma_addr, dma_stride, e[63:32], e[31:0]);
              else passed++;
            end
          end else begin
            nb++;
            if (qb.size() == 0) begin
              $display("FAIL b_req unexpected got=%h", dma_addr);
            end else begin
              e = qb.pop_front();
              if ({dma_addr, dma_stride} !== e)
                $display("FAIL b_req got=%h/%h exp=%h/%h",
                  dma_addr, dma_stride, e[63:32], e[31:0]);
              else passed++;
            end
          end
        end
        if (comp_start) begin
          nc++;
          if (comp_first) nfirst++;
          if (comp_last) nlast++;
          total++;
          if (qc.size() == 0) begin
            $display("FAIL comp unexpected");
          end else begin
            f = qc.pop_front();
            if ({comp_first, comp_last} !== f)
              $display("FAIL comp_flags got=%b exp=%b",
                {comp_first, comp_last}, f);
            else passed++;
          end
        end
        if (wb_start) begin
          nw++;
          total++;
          if (qw.size() == 0) begin
            $display("FAIL wb unexpected got=%h", wb_addr);
          end else begin
            e = qw.pop_front();
            if ({wb_addr, wb_stride} !== e)
              $display("FAIL wb got=%h/%h exp=%h/%h",
                wb_addr, wb_stride, e[63:32], e[31:0]);
            else passed++;
          end
        end
        if (done) ndone++;
      end
      prev_req = dma_req;
    end
  end

  // Responder: ack after 3 request cycles, dma_done 3 cycles
  // after ack; comp_done / wb_done 2 cycles after their start.
  initial begin
    int ack_cnt, dd_cnt, cd_cnt, wd_cnt;
    dma_ack = 0; dma_done = 0; comp_done = 0; wb_done = 0;
    ack_cnt = 0; dd_cnt = 0; cd_cnt = 0; wd_cnt = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        ack_cnt = 0; dd_cnt = 0; cd_cnt = 0; wd_cnt = 0;
      end else if (rst) begin
        dma_ack = 0; dma_done = 0; comp_done = 0; wb_done = 0;
        ack_cnt = 0; dd_cnt = 0; cd_cnt = 0; wd_cnt = 0;
      end else begin
        dma_done = 0; comp_done = 0; wb_done = 0;
        if (dd_cnt > 0) begin
          dd_cnt--;
          if (dd_cnt == 0) dma_done = 1;
        end
        if (cd_cnt > 0) begin
          cd_cnt--;
          if (cd_cnt == 0) comp_done = 1;
        end
        if (wd_cnt > 0) begin
          wd_cnt--;
          if (wd_cnt == 0) begin
            total++;
            if ({wb_addr, wb_stride} !== wb_hold)
              $display("FAIL wb_stable got=%h/%h exp=%h",
                wb_addr, wb_stride, wb_hold);
            else passed++;
            wb_done = 1;
          end
        end
        if (dma_ack) begin
          dma_ack = 0;
          dd_cnt = 3;
        end else if (dma_req) begin
          if (ack_cnt >= 2) begin
            dma_ack = 1;
            ack_cnt = 0;
          end else ack_cnt++;
        end
        if (comp_start) cd_cnt = 2;
        if (wb_start) begin
          wd_cnt = 2;
          wb_hold = {wb_addr, wb_stride};
        end
      end
    end
  end

  task automatic push_job(input int mm, input int kk, input int nn);
    logic [31:0] a, b, c, km, nm;
    km = 32'(kk);
    nm = 32'(nn);
    for (int ti = 0; ti < mm / SIZE; ti++)
      for (int tj = 0; tj < nn / SIZE; tj++) begin
        for (int tk = 0; tk < kk / SIZE; tk++) begin
          a = addr_base_a
            + 32'((ti * SIZE * kk + tk * SIZE) * EB);
          b = addr_base_b
            + 32'((tk * SIZE * nn + tj * SIZE) * EB);
          qa.push_back({a, km * EB});
          qb.push_back({b, nm * EB});
          qc.push_back({tk == 0, tk == kk / SIZE - 1});
        end
        c = addr_base_c
          + 32'((ti * SIZE * nn + tj * SIZE) * EB);
        qw.push_back({c, nm * EB});
      end
  endtask

  task automatic clear_sb();
    qa.delete(); qb.delete(); qw.delete(); qc.delete();
    na = 0; nb = 0; nc = 0; nfirst = 0;
    nlast = 0; nw = 0; ndone = 0;
  endtask

  task automatic set_cfg(input int mm, input int kk, input int nn);
    addr_base_a = 32'h1000_0010;
    addr_base_b = 32'h2000_0100;
    addr_base_c = 32'h3000_0000;
    m = 32'(mm); k = 32'(kk); n = 32'(nn);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    total++;
    if (!ok) $display("FAIL %s timeout waiting for done", nm);
    else passed++;
  endtask

  task automatic check_counts(input string nm, input int exp_n,
                              input int exp_w, input int exp_d);
    total++;
    if (na !== exp_n || nb !== exp_n || nc !== exp_n
        || nw !== exp_w || ndone !== exp_d)
      $display("FAIL %s counts a=%0d b=%0d c=%0d w=%0d d=%0d exp %0d/%0d/%0d",
        nm, na, nb, nc, nw, ndone, exp_n, exp_w, exp_d);
    else passed++;
    total++;
    if (qa.size() + qb.size() + qc.size() + qw.size() != 0)
      $display("FAIL %s leftover expected=%0d", nm,
        qa.size() + qb.size() + qc.size() + qw.size());
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (outs !== '0) $display("FAIL reset_outs got=%h exp=0", outs);
    else passed++;
  endtask

  task automatic test_main();
    clear_sb();
    set_cfg(16, 16, 16);
    push_job(16, 16, 16);
    pulse_start();
    total++;
    if ({busy, dma_req, dma_sel} !== 3'b110)
      $display("FAIL first_req busy/req/sel got=%b exp=110",
        {busy, dma_req, dma_sel});
    else passed++;
    total++;
    if (dma_addr !== 32'h1000_0010 || dma_stride !== 32'd16)
      $display("FAIL first_a got=%h/%0d exp=10000010/16",
        dma_addr, dma_stride);
    else passed++;
    wait_done("main");
    total++;
    if (busy !== 1'b0 || err !== 1'b0)
      $display("FAIL main_done busy=%b err=%b exp 0/0", busy, err);
    else passed++;
    @(negedge clk);
    check_counts("main", 8, 4, 1);
    total++;
    if (nfirst !== 4 || nlast !== 4)
      $display("FAIL main_flags first=%0d last=%0d exp 4/4",
        nfirst, nlast);
    else passed++;
  endtask

  task automatic test_config_err();
    int dims[2][3] = '{'{16, 0, 8}, '{12, 16, 16}};
    for (int c = 0; c < 2; c++) begin
      clear_sb();
      set_cfg(dims[c][0], dims[c][1], dims[c][2]);
      pulse_start();
      total++;
      if ({done, err, busy, dma_req} !== 4'b1100)
        $display("FAIL cfg_err%0d done/err/busy/req got=%b exp=1100",
          c, {done, err, busy, dma_req});
      else passed++;
      repeat (5) @(negedge clk);
      total++;
      if (err !== 1'b1 || na !== 0 || nb !== 0)
        $display("FAIL cfg_err%0d sticky err=%b reqs=%0d exp 1/0",
          c, err, na + nb);
      else passed++;
    end
    clear_sb();
    set_cfg(16, 16, 16);
    push_job(16, 16, 16);
    pulse_start();
    total++;
    if (err !== 1'b0) $display("FAIL err_clear got=%b exp=0", err);
    else passed++;
    wait_done("err_clear");
    @(negedge clk);
    check_counts("err_clear", 8, 4, 1);
  endtask

  task automatic test_stall_spurious();
    bit stable = 1;
    mon_en = 0;
    resp_en = 0;
    set_cfg(16, 16, 16);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      dma_done = i[0];
      comp_done = ~i[0];
      @(negedge clk);
      if (dma_req !== 1'b1 || dma_sel !== 1'b0
          || dma_addr !== 32'h1000_0010 || dma_stride !== 32'd16)
        stable = 0;
    end
    dma_done = 0;
    comp_done = 0;
    total++;
    if (!stable)
      $display("FAIL stall_hold req=%b addr=%h exp 1/10000010",
        dma_req, dma_addr);
    else passed++;
    dma_ack = 1;
    dma_done = 1;
    @(negedge clk);
    dma_ack = 0;
    dma_done = 0;
    comp_done = 1;
    repeat (3) @(negedge clk);
    comp_done = 0;
    total++;
    if (dma_req !== 1'b0)
      $display("FAIL spurious_done req=%b exp=0", dma_req);
    else passed++;
    dma_done = 1;
    @(negedge clk);
    dma_done = 0;
    total++;
    if ({dma_req, dma_sel} !== 2'b11 || dma_addr !== 32'h2000_0100)
      $display("FAIL b_after_done req/sel=%b addr=%h exp 11/20000100",
        {dma_req, dma_sel}, dma_addr);
    else passed++;
    do_reset();
    resp_en = 1;
    mon_en = 1;
  endtask

  task automatic test_reset_midrun();
    bit hit = 0;
    clear_sb();
    set_cfg(16, 16, 16);
    push_job(16, 16, 16);
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (nb >= 3 && !dma_req) begin hit = 1; break; end
    end
    total++;
    if (!hit || nc !== 2)
      $display("FAIL midrun_reach hit=%0d comps=%0d exp 1/2", hit, nc);
    else passed++;
    rst = 1;
    @(negedge clk);
    total++;
    if (outs !== '0) $display("FAIL midrun_rst got=%h exp=0", outs);
    else passed++;
    @(negedge clk) rst = 0;
    clear_sb();
    push_job(16, 16, 16);
    pulse_start();
    total++;
    if (dma_req !== 1'b1 || dma_addr !== 32'h1000_0010)
      $display("FAIL rerun_first req=%b addr=%h exp 1/10000010",
        dma_req, dma_addr);
    else passed++;
    wait_done("rerun");
    @(negedge clk);
    check_counts("rerun", 8, 4, 1);
  endtask

  task automatic test_back_to_back();
    clear_sb();
    set_cfg(16, 16, 16);
    push_job(16, 16, 16);
    push_job(16, 16, 16);
    pulse_start();
    repeat (20) @(negedge clk);
    addr_base_a = 32'hdead_0000;
    m = 32'd8; k = 32'd24; n = 32'd0;
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    set_cfg(16, 16, 16);
    wait_done("b2b_first");
    pulse_start();
    total++;
    if (busy !== 1'b1 || dma_req !== 1'b1)
      $display("FAIL b2b_restart busy=%b req=%b exp 1/1", busy, dma_req);
    else passed++;
    wait_done("b2b_second");
    @(negedge clk);
    check_counts("b2b", 16, 8, 2);
  endtask

  initial begin
    rst = 1; start = 0; mon_en = 1; resp_en = 1;
    set_cfg(16, 16, 16);
    clear_sb();
    test_reset();
    test_main();
    test_config_err();
    test_stall_spurious();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
